start_signal_ctrl: RTL and testbench



---
 rtl/start_signal_pkg.sv | 32 +++
 rtl/start_signal_debounce.sv | 53 +++++
 rtl/start_signal_ctrl.sv | 96 +++++++++
 tb/tb_start_signal_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/start_signal_pkg.sv
// Shared types and status-word layout for the capture-start controller.
package start_signal_pkg;

    localparam int FRAME_CNT_W  = 12;

    localparam int ST_BUSY      = 0;
    localparam int ST_DONE      = 1;
    localparam int ST_STATE_LSB = 2;
    localparam int ST_CNT_LSB   = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    function automatic logic [15:0] pack_status(
        input state_t                 st,
        input logic                   done,
        input logic [FRAME_CNT_W-1:0] cnt
    );
        logic [15:0] w_word;
        w_word                           = 16'h0000;
        w_word[ST_BUSY]                  = (st == S_ARMED) || (st == S_CAPTURE);
        w_word[ST_DONE]                  = done;
        w_word[ST_STATE_LSB +: 2]        = st;
        w_word[ST_CNT_LSB +: FRAME_CNT_W] = cnt;
        return w_word;
    endfunction

endpackage

// File: rtl/start_signal_debounce.sv
// Pushbutton synchronizer, debouncer and debounced-press pulse generator.
module start_signal_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_key_n,
    output logic o_press
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DB_W-1:0]        r_db_cnt;
    logic                   r_key_db;
    logic                   r_key_db_d;
    logic                   w_key_s;

    assign w_key_s = r_sync[SYNC_STAGES-1];

    // Synchronizer chain, resets to the released level.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_key_n};
        end
    end

    // Debounced level only follows a mismatch that survives DEBOUNCE_CYCLES cycles.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_db_cnt   <= '0;
            r_key_db   <= 1'b1;
            r_key_db_d <= 1'b1;
        end else begin
            r_key_db_d <= r_key_db;
            if (w_key_s == r_key_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_key_db <= w_key_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_key_db_d & ~r_key_db;

endmodule

// File: rtl/start_signal_ctrl.sv
// Capture-start controller: press arms, next vsync opens a one-frame window,
// following vsync closes it and bumps the frame count. Status feeds the PIO.
module start_signal_ctrl
    import start_signal_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_key_n,
    input  logic        i_frame_vsync,
    output logic        o_capture_active,
    output logic [15:0] o_status
);

    logic                   w_press;
    logic                   w_vs_s;
    logic                   w_vs_rise;
    logic [SYNC_STAGES-1:0] r_vs_sync;
    logic                   r_vs_d;
    state_t                 r_state;
    logic                   r_done;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   r_capture_active;

    start_signal_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_key_n   (i_key_n),
        .o_press   (w_press)
    );

    assign w_vs_s    = r_vs_sync[SYNC_STAGES-1];
    assign w_vs_rise = w_vs_s & ~r_vs_d;

    // Vsync synchronizer and one-cycle delay for rising-edge detection.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_vs_sync <= '0;
            r_vs_d    <= 1'b0;
        end else begin
            r_vs_sync <= {r_vs_sync[SYNC_STAGES-2:0], i_frame_vsync};
            r_vs_d    <= w_vs_s;
        end
    end

    // Capture FSM; a coincident press and vsync in IDLE/DONE only arms.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state          <= S_IDLE;
            r_done           <= 1'b0;
            r_frame_cnt      <= '0;
            r_capture_active <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (w_vs_rise) begin
                        r_state          <= S_CAPTURE;
                        r_capture_active <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (w_vs_rise) begin
                        r_state          <= S_DONE;
                        r_capture_active <= 1'b0;
                        r_done           <= 1'b1;
                        r_frame_cnt      <= r_frame_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_press) begin
                        r_state <= S_ARMED;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state          <= S_IDLE;
                    r_capture_active <= 1'b0;
                end
            endcase
        end
    end

    assign o_capture_active = r_capture_active;
    assign o_status         = pack_status(r_state, r_done, r_frame_cnt);

endmodule

// File: tb/tb_start_signal_ctrl.sv
// Directed bench for start_signal_ctrl with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_start_signal_ctrl;

    logic        clk;
    logic        reset_n;
    logic        key_n;
    logic        vsync;
    logic        cap;
    logic [15:0] status;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        key_n;
        logic        vs;
        int          cycles;
        logic [15:0] st;
        logic        cap;
        logic        press;
    } vec_t;

    vec_t tbl [25];

    start_signal_ctrl #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .i_clk            (clk),
        .i_reset_n        (reset_n),
        .i_key_n          (key_n),
        .i_frame_vsync    (vsync),
        .o_capture_active (cap),
        .o_status         (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // Stimulus table: inputs held for N cycles, then outputs compared.
        tbl[0]  = '{1'b0, 1'b0, 3,  16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 12, 16'h0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 5,  16'h0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1,  16'h0000, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1,  16'h0005, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 3,  16'h0005, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 10, 16'h0005, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 2,  16'h0005, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1,  16'h0009, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8,  16'h0009, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 2,  16'h0009, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1,  16'h001E, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8,  16'h001E, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 7,  16'h0015, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 3,  16'h0015, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 10, 16'h0015, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 3,  16'h0019, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 5,  16'h0019, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 6,  16'h0019, 1'b1, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 4,  16'h0019, 1'b1, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 10, 16'h0019, 1'b1, 1'b0};
        tbl[21] = '{1'b1, 1'b1, 3,  16'h002E, 1'b0, 1'b0};
        tbl[22] = '{1'b1, 1'b0, 5,  16'h002E, 1'b0, 1'b0};
        tbl[23] = '{1'b1, 1'b1, 3,  16'h002E, 1'b0, 1'b0};
        tbl[24] = '{1'b1, 1'b0, 5,  16'h002E, 1'b0, 1'b0};

        reset_n = 1'b0;
        key_n   = 1'b1;
        vsync   = 1'b0;
        tick(3);
        check("reset_status", status, 16'h0000);
        check("reset_cap", {15'd0, cap}, 16'h0000);
        reset_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            tick(1);
            check("idle_status", status, 16'h0000);
            check("idle_cap", {15'd0, cap}, 16'h0000);
        end

        for (int i = 0; i < 25; i++) begin
            key_n = tbl[i].key_n;
            vsync = tbl[i].vs;
            tick(tbl[i].cycles);
            check($sformatf("vec%0d_status", i), status, tbl[i].st);
            check($sformatf("vec%0d_cap", i), {15'd0, cap}, {15'd0, tbl[i].cap});
            check($sformatf("vec%0d_press", i), {15'd0, dut.w_press}, {15'd0, tbl[i].press});
        end

        // Coincident press and vsync edge in IDLE: arm only.
        reset_n = 1'b0;
        key_n   = 1'b1;
        vsync   = 1'b0;
        tick(2);
        check("rst2_status", status, 16'h0000);
        reset_n = 1'b1;
        tick(1);
        key_n = 1'b0;
        tick(4);
        vsync = 1'b1;
        tick(2);
        check("coinc_press", {15'd0, dut.w_press}, 16'h0001);
        check("coinc_vsrise", {15'd0, dut.w_vs_rise}, 16'h0001);
        tick(1);
        check("coinc_armed", status, 16'h0005);
        check("coinc_cap", {15'd0, cap}, 16'h0000);
        tick(5);
        check("coinc_hold", status, 16'h0005);
        key_n = 1'b1;
        tick(8);
        vsync = 1'b0;
        tick(2);
        vsync = 1'b1;
        tick(3);
        check("midcap_status", status, 16'h0009);
        reset_n = 1'b0;
        tick(1);
        check("abort_status", status, 16'h0000);
        check("abort_cap", {15'd0, cap}, 16'h0000);
        reset_n = 1'b1;
        tick(5);
        check("abort_idle", status, 16'h0000);

        // Frame counter wrap from 4095 with done held.
        vsync = 1'b0;
        key_n = 1'b0;
        tick(7);
        check("wrap_armed", status, 16'h0005);
        key_n = 1'b1;
        tick(8);
        vsync = 1'b1;
        tick(3);
        check("wrap_capture", status, 16'h0009);
        vsync = 1'b0;
        tick(2);
        force dut.r_frame_cnt = 12'hFFF;
        tick(1);
        release dut.r_frame_cnt;
        tick(3);
        check("wrap_preload", status, 16'hFFF9);
        vsync = 1'b1;
        tick(3);
        check("wrap_status", status, 16'h000E);
        check("wrap_cap", {15'd0, cap}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
